// File: rtl/data_cache_controller.sv
`default_nettype none
// ============================================================================
// Module   : data_cache_controller
// Purpose  : Direct-mapped, write-back, write-allocate data cache placed
//            between a 32-bit word load/store unit and a 128-bit block memory.
//            CPU hits are served with zero stall; misses write back a dirty
//            victim (if any), fill the block and then complete as a hit.
// Ports    : clock, reset         - clock, asynchronous active-high reset
//            cpu_read/cpu_write   - word request, held while cpu_busywait=1
//            cpu_address          - byte address (tag | index | word | byte)
//            cpu_writedata        - store data
//            cpu_readdata         - load data, valid on a read with no stall
//            cpu_busywait         - CPU stall
//            mem_read/mem_write   - block read / write-back request
//            mem_address          - block address (byte address [31:4])
//            mem_writedata        - victim block, byte 0 in [7:0]
//            mem_readdata         - fill block, same byte order
//            mem_busywait         - memory busy
// Revision : 1.0 - initial release
// ============================================================================
module data_cache_controller #(
    parameter int INDEX_BITS = 3,
    // Derived from INDEX_BITS; leave at its default.
    parameter int TAG_BITS   = 28 - INDEX_BITS
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         cpu_read,
    input  logic         cpu_write,
    input  logic [31:0]  cpu_address,
    input  logic [31:0]  cpu_writedata,
    output logic [31:0]  cpu_readdata,
    output logic         cpu_busywait,
    output logic         mem_read,
    output logic         mem_write,
    output logic [27:0]  mem_address,
    output logic [127:0] mem_writedata,
    input  logic [127:0] mem_readdata,
    input  logic         mem_busywait
);

    localparam int SETS = 1 << INDEX_BITS;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITEBACK = 2'd1,
        ALLOCATE  = 2'd2,
        UPDATE    = 2'd3
    } state_t;

    state_t         state_q, state_d;
    // Set after the first cycle in WRITEBACK/ALLOCATE; mem_busywait is only
    // honoured once it is set, giving memory a cycle to raise busywait.
    logic           armed_q, armed_d;
    logic [27:0]    mem_address_q, mem_address_d;
    logic [127:0]   mem_writedata_q, mem_writedata_d;

    // Storage arrays. Data and tag are not reset; valid/dirty are.
    logic [127:0]        data_q  [SETS];
    logic [TAG_BITS-1:0] tag_q   [SETS];
    logic [SETS-1:0]     valid_q, valid_d;
    logic [SETS-1:0]     dirty_q, dirty_d;

    // Address fields
    logic [INDEX_BITS-1:0] addr_index;
    logic [TAG_BITS-1:0]   addr_tag;
    logic [1:0]            word_sel;
    logic                  unused_addr_bits;

    assign addr_index       = cpu_address[3+INDEX_BITS:4];
    assign addr_tag         = cpu_address[31:4+INDEX_BITS];
    assign word_sel         = cpu_address[3:2];
    assign unused_addr_bits = ^cpu_address[1:0];

    // Both request lines high is treated as no request at all.
    logic req_read, req_write, req;
    assign req_read  = cpu_read & ~cpu_write;
    assign req_write = cpu_write & ~cpu_read;
    assign req       = req_read | req_write;

    // Currently indexed line
    logic [127:0]        cur_block;
    logic [TAG_BITS-1:0] cur_tag;
    logic                cur_valid, cur_dirty, hit;
    logic [31:0]         selected_word;

    assign cur_block     = data_q[addr_index];
    assign cur_tag       = tag_q[addr_index];
    assign cur_valid     = valid_q[addr_index];
    assign cur_dirty     = dirty_q[addr_index];
    assign hit           = cur_valid & (cur_tag == addr_tag);
    assign selected_word = cur_block[{word_sel, 5'd0} +: 32];

    // Array write controls
    logic           block_we;
    logic [127:0]   block_d;
    logic           tag_we;
    logic [TAG_BITS-1:0] tag_d;

    // ------------------------------------------------------------------
    // Next-state and output logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d         = state_q;
        armed_d         = armed_q;
        mem_address_d   = mem_address_q;
        mem_writedata_d = mem_writedata_q;
        valid_d         = valid_q;
        dirty_d         = dirty_q;
        block_we        = 1'b0;
        block_d         = cur_block;
        tag_we          = 1'b0;
        tag_d           = addr_tag;
        cpu_readdata    = 32'd0;
        cpu_busywait    = 1'b0;
        mem_read        = 1'b0;
        mem_write       = 1'b0;
        // Memory outputs hold their last driven value outside a transfer.
        mem_address     = mem_address_q;
        mem_writedata   = mem_writedata_q;

        case (state_q)
            IDLE: begin
                armed_d = 1'b0;
                if (req) begin
                    if (hit) begin
                        if (req_read) begin
                            cpu_readdata = selected_word;
                        end else begin
                            block_we                         = 1'b1;
                            block_d[{word_sel, 5'd0} +: 32]  = cpu_writedata;
                            dirty_d[addr_index]              = 1'b1;
                        end
                    end else begin
                        cpu_busywait = 1'b1;
                        state_d      = (cur_valid & cur_dirty) ? WRITEBACK : ALLOCATE;
                    end
                end
            end

            WRITEBACK: begin
                mem_write       = 1'b1;
                mem_address     = {cur_tag, addr_index};
                mem_writedata   = cur_block;
                cpu_busywait    = 1'b1;
                mem_address_d   = {cur_tag, addr_index};
                mem_writedata_d = cur_block;
                armed_d         = 1'b1;
                if (armed_q && !mem_busywait) begin
                    state_d = ALLOCATE;
                    armed_d = 1'b0;
                end
            end

            ALLOCATE: begin
                mem_read      = 1'b1;
                mem_address   = cpu_address[31:4];
                cpu_busywait  = 1'b1;
                mem_address_d = cpu_address[31:4];
                armed_d       = 1'b1;
                if (armed_q && !mem_busywait) begin
                    state_d = UPDATE;
                    armed_d = 1'b0;
                end
            end

            UPDATE: begin
                // The fill lands at the end of this cycle; the request is
                // then seen again in IDLE as a hit.
                cpu_busywait        = 1'b1;
                block_we            = 1'b1;
                block_d             = mem_readdata;
                tag_we              = 1'b1;
                valid_d[addr_index] = 1'b1;
                dirty_d[addr_index] = 1'b0;
                state_d             = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        // While reset is held the FSM sits in IDLE with every line invalid,
        // which would otherwise stall a pending request.
        if (reset) begin
            cpu_busywait = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q         <= IDLE;
            armed_q         <= 1'b0;
            mem_address_q   <= 28'd0;
            mem_writedata_q <= 128'd0;
            valid_q         <= '0;
            dirty_q         <= '0;
        end else begin
            state_q         <= state_d;
            armed_q         <= armed_d;
            mem_address_q   <= mem_address_d;
            mem_writedata_q <= mem_writedata_d;
            valid_q         <= valid_d;
            dirty_q         <= dirty_d;
        end
    end

    // Data and tag arrays carry no reset. Writes only occur on a write hit
    // (needs a valid line) or in UPDATE, neither possible while in reset.
    always_ff @(posedge clock) begin
        if (block_we) begin
            data_q[addr_index] <= block_d;
        end
        if (tag_we) begin
            tag_q[addr_index] <= tag_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_data_cache_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_data_cache_controller
// Purpose  : Self-checking bench for data_cache_controller. A driver issues
//            directed and random word accesses and pushes the expected
//            outcome into a scoreboard queue; a monitor pops and compares on
//            each completed CPU access. A block memory model answers the
//            cache with random busy periods.
// Revision : 1.0 - initial release
// ============================================================================
module tb_data_cache_controller;

    localparam int SETS = 8;

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic         cpu_read = 1'b0;
    logic         cpu_write = 1'b0;
    logic [31:0]  cpu_address = 32'd0;
    logic [31:0]  cpu_writedata = 32'd0;
    logic [31:0]  cpu_readdata;
    logic         cpu_busywait;
    logic         mem_read;
    logic         mem_write;
    logic [27:0]  mem_address;
    logic [127:0] mem_writedata;
    logic [127:0] mem_readdata = 128'd0;
    logic         mem_busywait = 1'b0;

    always #5 clock = ~clock;

    data_cache_controller #(.INDEX_BITS(3)) dut (
        .clock         (clock),
        .reset         (reset),
        .cpu_read      (cpu_read),
        .cpu_write     (cpu_write),
        .cpu_address   (cpu_address),
        .cpu_writedata (cpu_writedata),
        .cpu_readdata  (cpu_readdata),
        .cpu_busywait  (cpu_busywait),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .mem_address   (mem_address),
        .mem_writedata (mem_writedata),
        .mem_readdata  (mem_readdata),
        .mem_busywait  (mem_busywait)
    );

    // ---------------------------------------------------------------
    // Counters and comparison helper
    // ---------------------------------------------------------------
    int checks = 0;
    int passes = 0;
    int overlap_cycles = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic finish_run();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    endtask

    task automatic timeout_abort(input string nm);
        checks++;
        $display("FAIL %s: timed out waiting for the cache", nm);
        finish_run();
    endtask

    // ---------------------------------------------------------------
    // Block memory model (byte 0 in [7:0], word w in [32w+31:32w])
    // ---------------------------------------------------------------
    logic [127:0] mem_blk [bit [27:0]];

    function automatic logic [127:0] init_blk(input logic [27:0] a);
        logic [127:0] b;
        for (int w = 0; w < 4; w++)
            b[32*w +: 32] = ({a[23:0], 8'h00} | 32'(w)) ^ 32'hA5C3_0F00;
        return b;
    endfunction

    function automatic logic [127:0] blk_rd(input logic [27:0] a);
        if (mem_blk.exists(a)) return mem_blk[a];
        return init_blk(a);
    endfunction

    initial begin : mem_model
        logic [1:0] kind, last_kind;
        int cnt;
        last_kind = 2'b00;
        cnt = 0;
        forever begin
            @(negedge clock);
            if (reset) begin
                last_kind    = 2'b00;
                mem_busywait = 1'b0;
            end else begin
                kind = {mem_read, mem_write};
                if (mem_read && mem_write) overlap_cycles++;
                if (mem_write) mem_blk[mem_address] = mem_writedata;
                if (kind == 2'b00) begin
                    mem_busywait = 1'b0;
                end else if (kind != last_kind) begin
                    cnt = $urandom_range(1, 4);
                    mem_busywait = 1'b1;
                end else begin
                    if (cnt > 0) cnt--;
                    mem_busywait = (cnt != 0);
                end
                last_kind    = kind;
                mem_readdata = blk_rd(mem_address);
            end
        end
    end

    // ---------------------------------------------------------------
    // Reference model: the cache is transparent, so every load returns
    // the last stored word (or memory's initial contents). Line residency
    // is tracked only to predict hit / write-back behaviour.
    // ---------------------------------------------------------------
    logic [31:0] gold [bit [29:0]];
    bit          mv [SETS];
    bit          md [SETS];
    logic [24:0] mt [SETS];

    function automatic logic [31:0] gold_rd(input logic [29:0] wa);
        logic [127:0] b;
        if (gold.exists(wa)) return gold[wa];
        b = blk_rd(wa[29:2]);
        return b[{wa[1:0], 5'd0} +: 32];
    endfunction

    // Reset loses every dirty line's unwritten stores.
    task automatic model_reset();
        for (int s = 0; s < SETS; s++) begin
            if (mv[s] && md[s])
                for (int w = 0; w < 4; w++) gold.delete({mt[s], 3'(s), 2'(w)});
            mv[s] = 1'b0;
            md[s] = 1'b0;
        end
    endtask

    typedef struct {
        bit          is_read;
        logic [31:0] data;
        bit          hit;
        bit          wb;
        logic [27:0] wb_addr;
        logic [27:0] fill_addr;
    } exp_t;

    exp_t sb[$];

    // ---------------------------------------------------------------
    // Monitor: pops one expectation per completed access
    // ---------------------------------------------------------------
    initial begin : monitor
        int stall;
        bit seen_wb, seen_fill;
        logic [27:0] wb_a, fill_a;
        exp_t e;
        stall = 0; seen_wb = 0; seen_fill = 0; wb_a = '0; fill_a = '0;
        forever begin
            @(negedge clock);
            if (reset) begin
                sb.delete();
                stall = 0; seen_wb = 0; seen_fill = 0;
                continue;
            end
            if (mem_write && !seen_wb)  begin seen_wb = 1;   wb_a = mem_address;   end
            if (mem_read && !seen_fill) begin seen_fill = 1; fill_a = mem_address; end
            if (cpu_read ^ cpu_write) begin
                if (cpu_busywait) begin
                    stall++;
                end else begin
                    if (sb.size() == 0) begin
                        chk("unexpected_completion", 1, 0);
                    end else begin
                        e = sb.pop_front();
                        if (e.is_read) chk("read_data", cpu_readdata, e.data);
                        chk("zero_stall_iff_hit", (stall == 0), e.hit);
                        chk("writeback_seen", seen_wb, e.wb);
                        if (e.wb) chk("writeback_addr", wb_a, e.wb_addr);
                        if (!e.hit) chk("fill_addr", fill_a, e.fill_addr);
                    end
                    stall = 0; seen_wb = 0; seen_fill = 0;
                end
            end
        end
    end

    // ---------------------------------------------------------------
    // Driver
    // ---------------------------------------------------------------
    task automatic do_op(input bit is_read, input logic [31:0] addr, input logic [31:0] data);
        exp_t e;
        int idx, n;
        logic [24:0] tg;
        idx = int'(addr[6:4]);
        tg  = addr[31:7];
        e.is_read   = is_read;
        e.hit       = mv[idx] && (mt[idx] == tg);
        e.wb        = !e.hit && mv[idx] && md[idx];
        e.wb_addr   = {mt[idx], addr[6:4]};
        e.fill_addr = addr[31:4];
        e.data      = gold_rd(addr[31:2]);
        if (!e.hit) begin
            mv[idx] = 1'b1;
            mt[idx] = tg;
            md[idx] = 1'b0;
        end
        if (!is_read) begin
            md[idx] = 1'b1;
            gold[addr[31:2]] = data;
        end
        sb.push_back(e);

        @(posedge clock); #1;
        cpu_read      = is_read;
        cpu_write     = !is_read;
        cpu_address   = addr;
        cpu_writedata = data;
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (cpu_busywait && n < 100);
        if (cpu_busywait) timeout_abort("access_completion");
        @(posedge clock); #1;
        cpu_read  = 1'b0;
        cpu_write = 1'b0;
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        logic [127:0] b;
        logic [31:0]  a;
        int n;

        for (int s = 0; s < SETS; s++) begin mv[s] = 0; md[s] = 0; mt[s] = '0; end
        mem_blk[28'h1] = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};

        // Reset state
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        chk("reset_busywait",  cpu_busywait,  0);
        chk("reset_mem_read",  mem_read,      0);
        chk("reset_mem_write", mem_write,     0);
        chk("reset_mem_addr",  mem_address,   0);
        chk("reset_mem_wdata", mem_writedata, 0);
        chk("reset_readdata",  cpu_readdata,  0);

        // Directed sequence
        do_op(1, 32'h0000_0010, 32'h0);            // miss, fill block 1
        do_op(1, 32'h0000_0018, 32'h0);            // hit, word 2
        do_op(0, 32'h0000_0014, 32'hDEAD_BEEF);    // write hit
        do_op(1, 32'h0000_0014, 32'h0);
        do_op(1, 32'h0000_0010, 32'h0);
        do_op(1, 32'h0000_0090, 32'h0);            // conflict, dirty write-back
        b = blk_rd(28'h1);
        chk("writeback_block1_word1", b[63:32], 32'hDEAD_BEEF);

        // Illegal request: both lines high
        @(posedge clock); #1;
        cpu_read = 1'b1; cpu_write = 1'b1; cpu_address = 32'h0000_0010;
        @(negedge clock);
        chk("illegal_busywait", cpu_busywait, 0);
        chk("illegal_no_memreq", {mem_read, mem_write}, 2'b00);
        @(posedge clock); @(negedge clock);
        chk("illegal_no_memreq_later", {mem_read, mem_write}, 2'b00);
        @(posedge clock); #1;
        cpu_read = 1'b0; cpu_write = 1'b0;
        do_op(1, 32'h0000_0090, 32'h0);            // contents unchanged: hit

        // Reset while in ALLOCATE (request abandoned, not scoreboarded)
        @(posedge clock); #1;
        cpu_read = 1'b1; cpu_address = 32'h0000_0110;
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (!mem_read && n < 50);
        if (!mem_read) timeout_abort("reach_allocate");
        #2 reset = 1'b1;
        #1;
        chk("async_reset_mem_read", mem_read, 0);
        chk("async_reset_mem_write", mem_write, 0);
        chk("async_reset_busywait", cpu_busywait, 0);
        cpu_read = 1'b0;
        model_reset();
        @(posedge clock); @(negedge clock);
        @(posedge clock); #1 reset = 1'b0;
        do_op(1, 32'h0000_0090, 32'h0);            // misses again

        // Random traffic over a small address pool to force hits and conflicts
        for (int i = 0; i < 300; i++) begin
            a = {25'($urandom_range(0, 3)), 3'($urandom_range(0, 7)),
                 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3))};
            do_op(1'($urandom_range(0, 1)), a, $urandom);
            if ($urandom_range(0, 3) == 0) @(posedge clock);
        end

        repeat (2) @(negedge clock);
        chk("scoreboard_drained", sb.size(), 0);
        chk("never_read_and_write", overlap_cycles, 0);
        finish_run();
    end

endmodule
`default_nettype wire
